// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_ctrl_pkg : shared types and RV32I field positions for the     |
// |                 pipeline hazard controller.                        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int c_rd_lsb  = 7;
  localparam int c_rd_msb  = 11;
  localparam int c_rs1_lsb = 15;
  localparam int c_rs1_msb = 19;
  localparam int c_rs2_lsb = 20;
  localparam int c_rs2_msb = 24;

  localparam int          c_reg_w   = 5;
  localparam int          c_wcnt_w  = 8;
  localparam logic [4:0]  c_x0      = 5'd0;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_ctrl_if : pipeline-side control/handshake bundle of the     |
// |                  hazard controller.                                |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      r1_inst;
  logic [31:0]      r2_inst;
  logic             r2_reg_wr;
  logic             r2_rd_en;
  logic             r2_wr_en;
  logic             br_taken;
  logic             dm_ready;
  logic             dm_req;
  logic             hold_pc;
  logic             hold_r1;
  logic             hold_r2;
  logic             flush_r1;
  logic             fwd_a;
  logic             fwd_b;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;

  // Core datapath side: supplies stage contents, consumes controls.
  modport master (
    output r1_inst, r2_inst, r2_reg_wr, r2_rd_en, r2_wr_en, br_taken, dm_ready,
    input  dm_req, hold_pc, hold_r1, hold_r2, flush_r1, fwd_a, fwd_b,
           mem_err, stall_cycles
  );

  modport slave (
    input  r1_inst, r2_inst, r2_reg_wr, r2_rd_en, r2_wr_en, br_taken, dm_ready,
    output dm_req, hold_pc, hold_r1, hold_r2, flush_r1, fwd_a, fwd_b,
           mem_err, stall_cycles
  );

endinterface : hazard_ctrl_if
`default_nettype wire

// File: rtl/fwd_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fwd_unit : stage-2 -> EX operand forwarding select generation.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  wire logic [31:0] i_r1_inst,
  input  wire logic [31:0] i_r2_inst,
  input  wire logic        i_r2_reg_wr,
  output logic             o_fwd_a,
  output logic             o_fwd_b
);

  logic [c_reg_w-1:0] w_rd2;
  logic [c_reg_w-1:0] w_rs1;
  logic [c_reg_w-1:0] w_rs2;
  logic               w_wb_live;
  logic               w_unused;

  assign w_rd2 = i_r2_inst[c_rd_msb:c_rd_lsb];
  assign w_rs1 = i_r1_inst[c_rs1_msb:c_rs1_lsb];
  assign w_rs2 = i_r1_inst[c_rs2_msb:c_rs2_lsb];

  // x0 is hard-wired zero, so a write to it never produces forwardable data.
  assign w_wb_live = i_r2_reg_wr & (w_rd2 != c_x0);

  assign o_fwd_a = w_wb_live & (w_rd2 == w_rs1);
  assign o_fwd_b = w_wb_live & (w_rd2 == w_rs2);

  assign w_unused = ^{i_r1_inst[31:25], i_r1_inst[14:0],
                      i_r2_inst[31:12], i_r2_inst[6:0]};

endmodule : fwd_unit
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_ctrl : memory wait-state stall, branch flush and forwarding |
// |               control for the three-stage pipeline.                |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  wire logic   clk,
  input  wire logic   reset_n,
  hazard_ctrl_if.slave bus
);

  localparam logic [c_wcnt_w-1:0] c_timeout = c_wcnt_w'(TIMEOUT);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_wcnt_w-1:0] r_wait_cnt;
  logic [c_wcnt_w-1:0] w_wait_cnt_nxt;
  logic                r_mem_err;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic w_mem_op;
  logic w_at_limit;
  logic w_hold;
  logic w_timeout;

  assign w_mem_op   = bus.r2_rd_en | bus.r2_wr_en;
  assign w_at_limit = (r_wait_cnt == c_timeout);
  assign w_hold     = w_mem_op & ~bus.dm_ready & ~w_at_limit;
  // The op retires unserviced in the cycle its wait count reaches the limit.
  assign w_timeout  = (r_state == WAIT) & w_mem_op & ~bus.dm_ready & w_at_limit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      IDLE: begin
        if (w_hold) begin
          w_state_nxt    = WAIT;
          w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        end else begin
          w_wait_cnt_nxt = '0;
        end
      end
      WAIT: begin
        if (w_hold) begin
          w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        end else begin
          w_state_nxt    = IDLE;
          w_wait_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_err <= 1'b0;
    end else if (w_timeout) begin
      r_mem_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (w_hold && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  fwd_unit u_fwd_unit (
    .i_r1_inst   (bus.r1_inst),
    .i_r2_inst   (bus.r2_inst),
    .i_r2_reg_wr (bus.r2_reg_wr),
    .o_fwd_a     (bus.fwd_a),
    .o_fwd_b     (bus.fwd_b)
  );

  assign bus.dm_req       = w_mem_op;
  assign bus.hold_pc      = w_hold;
  assign bus.hold_r1      = w_hold;
  assign bus.hold_r2      = w_hold;
  // A frozen EX keeps presenting the taken branch, so the flush just waits.
  assign bus.flush_r1     = bus.br_taken & ~w_hold;
  assign bus.mem_err      = r_mem_err;
  assign bus.stall_cycles = r_stall_cnt;

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_hazard_ctrl : scoreboard bench for hazard_ctrl (TIMEOUT=4).     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  typedef struct packed {
    logic        dm_req;
    logic        hold_pc;
    logic        hold_r1;
    logic        hold_r2;
    logic        flush_r1;
    logic        fwd_a;
    logic        fwd_b;
    logic        mem_err;
    logic [15:0] stall;
  } obs_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   exp_stall = 0;
  logic exp_err = 1'b0;
  obs_t exp_q[$];

  hazard_ctrl_if #(.CNT_W(16)) bus ();
  hazard_ctrl_if #(.CNT_W(3))  bus_s ();

  hazard_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  hazard_ctrl #(.TIMEOUT(4), .CNT_W(3)) dut_sat (
    .clk(clk), .reset_n(reset_n), .bus(bus_s)
  );

  assign bus_s.r1_inst   = bus.r1_inst;
  assign bus_s.r2_inst   = bus.r2_inst;
  assign bus_s.r2_reg_wr = bus.r2_reg_wr;
  assign bus_s.r2_rd_en  = bus.r2_rd_en;
  assign bus_s.r2_wr_en  = bus.r2_wr_en;
  assign bus_s.br_taken  = bus.br_taken;
  assign bus_s.dm_ready  = bus.dm_ready;

  always #5 clk = ~clk;

  function automatic logic [31:0] inst(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
  endfunction

  function automatic obs_t observe();
    return {bus.dm_req, bus.hold_pc, bus.hold_r1, bus.hold_r2, bus.flush_r1,
            bus.fwd_a, bus.fwd_b, bus.mem_err, bus.stall_cycles};
  endfunction

  function automatic obs_t mk(input logic req, input logic hold, input logic fl,
                              input logic fa, input logic fb, input logic err,
                              input int st);
    return {req, hold, hold, hold, fl, fa, fb, err, 16'(st)};
  endfunction

  task automatic set_idle();
    bus.r1_inst = '0; bus.r2_inst = '0; bus.r2_reg_wr = 0; bus.r2_rd_en = 0;
    bus.r2_wr_en = 0; bus.br_taken = 0; bus.dm_ready = 0;
  endtask

  task automatic test_reset();
    obs_t e, g;
    set_idle();
    reset_n = 0;
    #1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    e = exp_q.pop_front(); g = observe(); checks++;
    if (g !== e) begin failures++; $display("FAIL reset got=%h exp=%h", g, e); end
    checks++;
    if (bus_s.stall_cycles !== 3'd0) begin
      failures++; $display("FAIL reset_sat got=%0d exp=0", bus_s.stall_cycles);
    end
    @(posedge clk); #1;
    reset_n = 1; exp_stall = 0; exp_err = 0;
  endtask

  task automatic test_zero_wait();
    obs_t e, g;
    bus.r2_inst = inst(5, 0, 0); bus.r2_reg_wr = 1; bus.r2_rd_en = 1;
    bus.dm_ready = 1; bus.r1_inst = inst(1, 5, 6);
    exp_q.push_back(mk(1, 0, 0, 1, 0, exp_err, exp_stall));
    @(negedge clk);
    e = exp_q.pop_front(); g = observe(); checks++;
    if (g !== e) begin failures++; $display("FAIL zero_wait got=%h exp=%h", g, e); end
    @(posedge clk); #1;
    set_idle();
    exp_q.push_back(mk(0, 0, 0, 0, 0, exp_err, exp_stall));
    @(negedge clk);
    e = exp_q.pop_front(); g = observe(); checks++;
    if (g !== e) begin failures++; $display("FAIL zero_wait_after got=%h exp=%h", g, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_n_wait();
    obs_t e, g;
    logic hold;
    bus.r2_inst = inst(0, 1, 2); bus.r2_wr_en = 1; bus.r1_inst = inst(3, 4, 5);
    for (int k = 0; k <= 3; k++) begin
      bus.dm_ready = (k == 3);
      hold = (k < 3);
      exp_q.push_back(mk(1, hold, 0, 0, 0, exp_err, exp_stall));
      @(negedge clk);
      e = exp_q.pop_front(); g = observe(); checks++;
      if (g !== e) begin failures++; $display("FAIL n_wait k=%0d got=%h exp=%h", k, g, e); end
      checks++;
      if (dut.r_state !== ((k == 0) ? IDLE : WAIT)) begin
        failures++; $display("FAIL n_wait_state k=%0d got=%0d", k, dut.r_state);
      end
      if (hold) exp_stall++;
      @(posedge clk); #1;
    end
    set_idle();
    @(negedge clk);
    checks++;
    if (dut.r_state !== IDLE || bus.stall_cycles !== 16'(3) || bus.mem_err !== 1'b0) begin
      failures++;
      $display("FAIL n_wait_end state=%0d stall=%0d err=%b exp IDLE/3/0",
               dut.r_state, bus.stall_cycles, bus.mem_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    obs_t e, g;
    logic hold;
    bus.r2_inst = inst(9, 0, 0); bus.r2_reg_wr = 1; bus.r2_rd_en = 1;
    bus.r1_inst = inst(1, 2, 3);
    for (int k = 0; k <= 6; k++) begin
      bus.dm_ready = (k == 5);
      if (k == 6) set_idle();
      hold = (k < 4);
      exp_q.push_back(mk(k < 6, hold, 0, 0, 0, exp_err, exp_stall));
      @(negedge clk);
      e = exp_q.pop_front(); g = observe(); checks++;
      if (g !== e) begin failures++; $display("FAIL timeout k=%0d got=%h exp=%h", k, g, e); end
      if (hold) exp_stall++;
      if (k == 4) exp_err = 1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    obs_t e, g;
    logic hold;
    bus.br_taken = 1; bus.r2_inst = inst(0, 7, 8); bus.r2_wr_en = 1;
    bus.r1_inst = inst(2, 3, 4);
    for (int k = 0; k <= 2; k++) begin
      bus.dm_ready = (k == 2);
      hold = (k < 2);
      exp_q.push_back(mk(1, hold, !hold, 0, 0, exp_err, exp_stall));
      @(negedge clk);
      e = exp_q.pop_front(); g = observe(); checks++;
      if (g !== e) begin failures++; $display("FAIL flush k=%0d got=%h exp=%h", k, g, e); end
      if (hold) exp_stall++;
      @(posedge clk); #1;
    end
    set_idle();
  endtask

  task automatic test_fwd();
    obs_t e, g;
    logic [4:0] rd2[4] = '{5'd0, 5'd7, 5'd7, 5'd7};
    logic [4:0] rs1[4] = '{5'd0, 5'd3, 5'd7, 5'd7};
    logic [4:0] rs2[4] = '{5'd0, 5'd7, 5'd7, 5'd7};
    logic       wr[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic       fa[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic       fb[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      bus.r2_inst = inst(rd2[k], 5'd1, 5'd2); bus.r2_reg_wr = wr[k];
      bus.r1_inst = inst(5'd9, rs1[k], rs2[k]);
      exp_q.push_back(mk(0, 0, 0, fa[k], fb[k], exp_err, exp_stall));
      @(negedge clk);
      e = exp_q.pop_front(); g = observe(); checks++;
      if (g !== e) begin failures++; $display("FAIL fwd k=%0d got=%h exp=%h", k, g, e); end
      @(posedge clk); #1;
    end
    set_idle();
  endtask

  task automatic test_back_to_back();
    obs_t e, g;
    logic [8:0] rdy = 9'b0_0000_1000;
    logic [8:0] hld = 9'b0_1111_0111;
    for (int k = 0; k <= 8; k++) begin
      if (k < 4) begin
        bus.r2_inst = inst(0, 1, 1); bus.r2_wr_en = 1; bus.r2_rd_en = 0;
      end else begin
        bus.r2_inst = inst(4, 1, 1); bus.r2_wr_en = 0; bus.r2_rd_en = 1;
      end
      bus.dm_ready = rdy[k];
      exp_q.push_back(mk(1, hld[k], 0, 0, 0, exp_err, exp_stall));
      @(negedge clk);
      e = exp_q.pop_front(); g = observe(); checks++;
      if (g !== e) begin failures++; $display("FAIL b2b k=%0d got=%h exp=%h", k, g, e); end
      if (hld[k]) exp_stall++;
      @(posedge clk); #1;
    end
    set_idle();
  endtask

  task automatic test_ready_idle();
    obs_t e, g;
    bus.dm_ready = 1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk(0, 0, 0, 0, 0, exp_err, exp_stall));
      @(negedge clk);
      e = exp_q.pop_front(); g = observe(); checks++;
      if (g !== e) begin failures++; $display("FAIL ready_idle k=%0d got=%h exp=%h", k, g, e); end
      @(posedge clk); #1;
    end
    set_idle();
  endtask

  task automatic test_reset_mid_wait();
    obs_t e, g;
    bus.r2_inst = inst(6, 0, 0); bus.r2_reg_wr = 1; bus.r2_rd_en = 1;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(mk(1, 1, 0, 0, 0, exp_err, exp_stall));
      @(negedge clk);
      e = exp_q.pop_front(); g = observe(); checks++;
      if (g !== e) begin failures++; $display("FAIL rst_wait k=%0d got=%h exp=%h", k, g, e); end
      exp_stall++;
      @(posedge clk); #1;
    end
    #2;
    reset_n = 0;
    #1;
    exp_stall = 0; exp_err = 0;
    exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0));
    e = exp_q.pop_front(); g = observe(); checks++;
    if (g !== e) begin failures++; $display("FAIL rst_async got=%h exp=%h", g, e); end
    checks++;
    if (dut.r_state !== IDLE || dut.r_wait_cnt !== 8'd0 || bus_s.stall_cycles !== 3'd0) begin
      failures++;
      $display("FAIL rst_async_state state=%0d wcnt=%0d sat=%0d exp 0/0/0",
               dut.r_state, dut.r_wait_cnt, bus_s.stall_cycles);
    end
    @(posedge clk); #1;
    set_idle();
    reset_n = 1;
  endtask

  task automatic test_saturate();
    obs_t e, g;
    logic hold;
    int   exp_sat;
    bus.r2_inst = inst(8, 0, 0); bus.r2_rd_en = 1; bus.r2_reg_wr = 1;
    for (int k = 0; k <= 10; k++) begin
      if (k == 10) set_idle();
      hold = (k != 4) && (k < 9);
      exp_sat = (exp_stall > 7) ? 7 : exp_stall;
      exp_q.push_back(mk(k < 10, hold, 0, 0, 0, exp_err, exp_stall));
      @(negedge clk);
      e = exp_q.pop_front(); g = observe(); checks++;
      if (g !== e) begin failures++; $display("FAIL sat_main k=%0d got=%h exp=%h", k, g, e); end
      checks++;
      if (bus_s.stall_cycles !== 3'(exp_sat)) begin
        failures++;
        $display("FAIL sat_cnt k=%0d got=%0d exp=%0d", k, bus_s.stall_cycles, exp_sat);
      end
      if (hold) exp_stall++;
      if (k == 4) exp_err = 1;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_n_wait();
    test_timeout();
    test_flush();
    test_fwd();
    test_back_to_back();
    test_ready_idle();
    test_reset_mid_wait();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule : tb_hazard_ctrl
`default_nettype wire
